modulo_controlador_contador_7_bits: RTL

// - Sequencer for the 7-bit synchronous up/down T-flip-flop counter, used as an occupancy counter.
// - Takes two asynchronous event inputs (entrada/saida), synchronises them and edge-detects them.
// - Resolves events that arrive together and issues single-cycle enable pulses with up_down to the counter.
// - Reads back the counter value q_in to saturate at 0 and at MAX_COUNT and to raise full/empty flags.

---
 rtl/modulo_controlador_contador_7_bits_pkg.sv | 15 +
 rtl/modulo_controlador_contador_7_bits_detector_borda.sv | 27 ++
 rtl/modulo_controlador_contador_7_bits.sv | 120 ++++++++++++
 3 files changed

// File: rtl/modulo_controlador_contador_7_bits_pkg.sv
// Shared types and constants for the occupancy-counter controller.
package pkg_controlador_contador;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int CNT_W = 7;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/modulo_controlador_contador_7_bits_detector_borda.sv
// Synchroniser chain followed by a rising-edge detector; pulse is high for one cycle.
module modulo_detector_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic evt,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational pulse keeps input-to-pending latency at SYNC_STAGES+1.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/modulo_controlador_contador_7_bits.sv
// Sequencer for a 7-bit up/down occupancy counter: turns entry/exit events into saturating steps.
// Optional alarm output enabled by defining CONTROLE_ALARME_EN.
module modulo_controlador_contador_7_bits
  import pkg_controlador_contador::*;
#(
  parameter int MAX_COUNT   = 127,
  parameter int SYNC_STAGES = 2
`ifdef CONTROLE_ALARME_EN
  , parameter int ALARM_LEVEL = 100
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             evt_up,
  input  logic             evt_down,
  input  logic [CNT_W-1:0] q_in,
  output logic             enable,
  output logic             up_down,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             busy
`ifdef CONTROLE_ALARME_EN
  , output logic           alarm
`endif
);

  localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_COUNT);

  state_t state;
  logic   edge_up, edge_down;
  logic   pend_up, pend_down;

  modulo_detector_borda #(.SYNC_STAGES(SYNC_STAGES)) u_borda_up (
    .clk   (clk),
    .clr   (clr),
    .evt   (evt_up),
    .pulse (edge_up)
  );

  modulo_detector_borda #(.SYNC_STAGES(SYNC_STAGES)) u_borda_down (
    .clk   (clk),
    .clr   (clr),
    .evt   (evt_down),
    .pulse (edge_down)
  );

  // Pending flags: a fresh edge wins over the clear, so edges during STEP/SETTLE are kept.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      enable    <= 1'b0;
      up_down   <= DIR_UP;
      full      <= 1'b0;
      empty     <= 1'b1;
      reject    <= 1'b0;
      busy      <= 1'b0;
      pend_up   <= 1'b0;
      pend_down <= 1'b0;
    end else begin
      enable    <= 1'b0;
      reject    <= 1'b0;
      full      <= (q_in >= MAX_Q);
      empty     <= (q_in == '0);
      pend_up   <= pend_up | edge_up;
      pend_down <= pend_down | edge_down;
      case (state)
        IDLE: begin
          if (pend_up && pend_down) begin
            pend_up   <= edge_up;
            pend_down <= edge_down;
          end else if (pend_up) begin
            if (full) begin
              reject  <= 1'b1;
              pend_up <= edge_up;
            end else begin
              up_down <= DIR_UP;
              enable  <= 1'b1;
              busy    <= 1'b1;
              state   <= STEP;
            end
          end else if (pend_down) begin
            if (empty) begin
              reject    <= 1'b1;
              pend_down <= edge_down;
            end else begin
              up_down <= DIR_DOWN;
              enable  <= 1'b1;
              busy    <= 1'b1;
              state   <= STEP;
            end
          end
        end
        STEP: begin
          if (up_down == DIR_UP) pend_up <= edge_up;
          else                   pend_down <= edge_down;
          state <= SETTLE;
        end
        SETTLE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONTROLE_ALARME_EN
  localparam logic [CNT_W-1:0] ALARM_Q = CNT_W'(ALARM_LEVEL);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) alarm <= 1'b0;
    else      alarm <= (q_in >= ALARM_Q);
  end
`endif

endmodule
